// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: column-scanned 4x4 keypad with frame debounce and a small key-code FIFO.
// Key code = row*4 + col; snap bit index is col*4 + row.
module keypad_matrix_scanner #(
    parameter int SCAN_CNT_W     = 18,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] Cols_Out,
    input  logic [3:0] Rows_In,
    output logic [3:0] KeyCode,
    output logic       KeyValid,
    input  logic       KeyAck,
    output logic       KeyPressed,
    output logic       Overflow,
    input  logic       Overflow_Clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

    typedef enum logic {DRIVE, EVAL} state_t;

    state_t                state_q, state_d;
    logic [1:0]            col_q, col_d;
    logic [SCAN_CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]            cols_q, cols_d;
    logic [3:0]            rows_meta_q, rows_sync_q;
    logic [15:0]           snap_q, snap_d;
    logic [15:0]           prev_q, prev_d;
    logic [15:0]           stable_keys_q, stable_keys_d;
    logic [3:0]            stable_cnt_q, stable_cnt_d;
    logic                  key_pressed_q, key_pressed_d;
    logic                  overflow_q, overflow_d;
    logic [AW:0]           wr_q, wr_d, rd_q, rd_d;
    logic [3:0]            mem_q [FIFO_DEPTH];
    logic [3:0]            mem_d [FIFO_DEPTH];
    logic                  push, pop, full, empty, onehot;
    logic [3:0]            idx, code;

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        cnt_d         = cnt_q + 1'b1;
        snap_d        = snap_q;
        prev_d        = prev_q;
        stable_cnt_d  = stable_cnt_q;
        stable_keys_d = stable_keys_q;
        if (state_q == DRIVE) begin
            if (&cnt_q) begin
                snap_d[{col_q, 2'b00} +: 4] = ~rows_sync_q;
                cnt_d   = '0;
                col_d   = col_q + 2'd1;
                state_d = (col_q == 2'd3) ? EVAL : DRIVE;
            end
        end else begin
            cnt_d        = cnt_q;
            state_d      = DRIVE;
            stable_cnt_d = (snap_q != prev_q) ? 4'd0 :
                           (stable_cnt_q == DEB) ? DEB : stable_cnt_q + 4'd1;
            prev_d       = snap_q;
            if (stable_cnt_d == DEB)
                stable_keys_d = snap_q;
        end
        cols_d        = (state_d == EVAL) ? 4'hF : ~(4'b0001 << col_d);
        key_pressed_d = |stable_keys_d;
    end

    // A press is only a transition from idle to exactly one key; multi-key changes are ghosting.
    always_comb begin
        onehot = (stable_keys_d != '0) && ((stable_keys_d & (stable_keys_d - 16'd1)) == '0);
        idx = '0;
        for (int i = 0; i < 16; i++)
            if (stable_keys_d[i])
                idx = 4'(i);
        code  = {idx[1:0], idx[3:2]};
        push  = (state_q == EVAL) && (stable_keys_q == '0) && onehot;
        empty = (wr_q == rd_q);
        full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        pop   = KeyAck && !empty;
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = pop ? rd_q + 1'b1 : rd_q;
        if (push && (!full || pop)) begin
            mem_d[wr_q[AW-1:0]] = code;
            wr_d = wr_q + 1'b1;
        end
        overflow_d = (push && full && !pop) ? 1'b1 : Overflow_Clr ? 1'b0 : overflow_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= DRIVE;
            col_q         <= '0;
            cnt_q         <= '0;
            cols_q        <= 4'b1110;
            rows_meta_q   <= 4'hF;
            rows_sync_q   <= 4'hF;
            snap_q        <= '0;
            prev_q        <= '0;
            stable_keys_q <= '0;
            stable_cnt_q  <= '0;
            key_pressed_q <= 1'b0;
            overflow_q    <= 1'b0;
            wr_q          <= '0;
            rd_q          <= '0;
            mem_q         <= '{default: '0};
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            cnt_q         <= cnt_d;
            cols_q        <= cols_d;
            rows_meta_q   <= Rows_In;
            rows_sync_q   <= rows_meta_q;
            snap_q        <= snap_d;
            prev_q        <= prev_d;
            stable_keys_q <= stable_keys_d;
            stable_cnt_q  <= stable_cnt_d;
            key_pressed_q <= key_pressed_d;
            overflow_q    <= overflow_d;
            wr_q          <= wr_d;
            rd_q          <= rd_d;
            mem_q         <= mem_d;
        end
    end

    assign Cols_Out   = cols_q;
    assign KeyCode    = mem_q[rd_q[AW-1:0]];
    assign KeyValid   = !empty;
    assign KeyPressed = key_pressed_q;
    assign Overflow   = overflow_q;
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner: directed keypad-matrix bench; a model matrix turns pressed codes into row levels.
module tb_keypad_matrix_scanner;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  Cols_Out, Rows_In, KeyCode;
    logic        KeyValid, KeyAck = 1'b0, KeyPressed, Overflow, Overflow_Clr = 1'b0;
    logic [15:0] keys = '0;
    int          n_checks = 0;
    int          n_fail = 0;

    keypad_matrix_scanner #(.SCAN_CNT_W(3), .DEBOUNCE_SCANS(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .Cols_Out(Cols_Out), .Rows_In(Rows_In),
        .KeyCode(KeyCode), .KeyValid(KeyValid), .KeyAck(KeyAck),
        .KeyPressed(KeyPressed), .Overflow(Overflow), .Overflow_Clr(Overflow_Clr)
    );

    always #5 clk = ~clk;

    // keys[code] pressed pulls row (code/4) low while column (code%4) is driven.
    always_comb begin
        Rows_In = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!Cols_Out[c] && keys[r*4+c])
                    Rows_In[r] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_eval();
        for (int i = 0; i < 100; i++) begin
            step();
            if (Cols_Out == 4'hF)
                break;
        end
        check("eval_seen", {28'b0, Cols_Out}, 32'hF);
    endtask

    task automatic frames(input int n);
        repeat (n) wait_eval();
        step();
    endtask

    task automatic press(input int code);
        keys = 16'(1) << code;
        frames(6);
        keys = '0;
        frames(6);
    endtask

    task automatic ack();
        KeyAck = 1'b1;
        step();
        KeyAck = 1'b0;
    endtask

    task automatic pop_expect(input logic [3:0] code);
        check("head_valid", {31'b0, KeyValid}, 32'd1);
        check("head_code", {28'b0, KeyCode}, {28'b0, code});
        ack();
    endtask

    task automatic check_reset_outputs();
        check("rst_cols", {28'b0, Cols_Out}, 32'hE);
        check("rst_valid", {31'b0, KeyValid}, 32'd0);
        check("rst_pressed", {31'b0, KeyPressed}, 32'd0);
        check("rst_ovf", {31'b0, Overflow}, 32'd0);
        check("rst_code", {28'b0, KeyCode}, 32'd0);
    endtask

    initial begin
        logic [3:0] exp_cols;
        // 1: reset and scan sequence
        repeat (2) @(posedge clk);
        step();
        check_reset_outputs();
        rst_n = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            step();
            exp_cols = (k < 8) ? 4'b1110 : (k < 16) ? 4'b1101 : (k < 24) ? 4'b1011 :
                       (k < 32) ? 4'b0111 : (k == 32) ? 4'b1111 : 4'b1110;
            check("scan_cols", {28'b0, Cols_Out}, {28'b0, exp_cols});
        end
        // 2: single key 6, debounce boundary, hold, ack
        keys = 16'(1) << 6;
        frames(4);
        check("deb4_valid", {31'b0, KeyValid}, 32'd0);
        check("deb4_pressed", {31'b0, KeyPressed}, 32'd0);
        frames(1);
        check("deb5_valid", {31'b0, KeyValid}, 32'd1);
        check("deb5_code", {28'b0, KeyCode}, 32'd6);
        check("deb5_pressed", {31'b0, KeyPressed}, 32'd1);
        frames(10);
        check("hold_code", {28'b0, KeyCode}, 32'd6);
        ack();
        check("hold_single", {31'b0, KeyValid}, 32'd0);
        keys = '0;
        frames(6);
        check("release_pressed", {31'b0, KeyPressed}, 32'd0);
        // 3: bouncing key never commits
        for (int i = 0; i < 5; i++) begin
            keys = 16'(1) << 6;
            frames(2);
            keys = '0;
            frames(2);
            check("bounce_valid", {31'b0, KeyValid}, 32'd0);
            check("bounce_pressed", {31'b0, KeyPressed}, 32'd0);
        end
        // 4: five presses into a 4-deep FIFO
        press(0);
        press(5);
        press(10);
        press(15);
        check("full_ovf", {31'b0, Overflow}, 32'd0);
        press(3);
        check("drop_ovf", {31'b0, Overflow}, 32'd1);
        pop_expect(4'd0);
        pop_expect(4'd5);
        pop_expect(4'd10);
        pop_expect(4'd15);
        check("drained_valid", {31'b0, KeyValid}, 32'd0);
        check("ovf_sticky", {31'b0, Overflow}, 32'd1);
        Overflow_Clr = 1'b1;
        step();
        Overflow_Clr = 1'b0;
        check("ovf_clr", {31'b0, Overflow}, 32'd0);
        // 5: push and pop in the same cycle while full
        press(2);
        press(4);
        press(7);
        press(8);
        keys = 16'(1) << 11;
        frames(4);
        wait_eval();
        KeyAck = 1'b1;
        step();
        KeyAck = 1'b0;
        check("pushpop_ovf", {31'b0, Overflow}, 32'd0);
        keys = '0;
        frames(6);
        pop_expect(4'd4);
        pop_expect(4'd7);
        pop_expect(4'd8);
        pop_expect(4'd11);
        check("pushpop_empty", {31'b0, KeyValid}, 32'd0);
        // 6: two keys held together, then mid-frame reset
        keys = (16'(1) << 1) | (16'(1) << 9);
        frames(6);
        check("multi_pressed", {31'b0, KeyPressed}, 32'd1);
        check("multi_valid", {31'b0, KeyValid}, 32'd0);
        repeat (12) step();
        rst_n = 1'b0;
        repeat (2) step();
        check_reset_outputs();
        rst_n = 1'b1;
        repeat (7) step();
        check("restart_col0", {28'b0, Cols_Out}, 32'hE);
        step();
        check("restart_col1", {28'b0, Cols_Out}, 32'hD);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
